// File: rtl/mux_scan_nto1.sv
// Registered N:1 channel multiplexer with a valid/ready output and a round-robin scan over a channel mask.
// Build option: define MUX_CH_TAG_EN to add the registered channel tag output out_sel.
module mux_scan_nto1 #(
  parameter int NUM_CH = 32,
  parameter int WIDTH  = 1,
  parameter int SEL_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data
`ifdef MUX_CH_TAG_EN
  ,
  output logic [SEL_W-1:0]        out_sel
`endif
);

  typedef enum logic {
    ST_MAN  = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  ptr;

  logic              load;
  logic [SEL_W-1:0]  scan_start;
  logic [NUM_CH-1:0] upper_mask;
  logic              scan_hit;
  logic [SEL_W-1:0]  scan_ch;
  logic [SEL_W-1:0]  scan_next;
  logic              man_hit;

  logic              cap_valid;
  logic [SEL_W-1:0]  cap_ch;
  logic [WIDTH-1:0]  cap_data;
  logic [SEL_W-1:0]  ptr_next;

  // Index of the lowest set bit; callers only use the result when v is non-zero.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  function automatic logic [WIDTH-1:0] chan_data(input logic [NUM_CH*WIDTH-1:0] d,
                                                  input logic [SEL_W-1:0]        idx);
    chan_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == idx) chan_data = d[i*WIDTH +: WIDTH];
    end
  endfunction

  assign load = !out_valid || out_ready;

  // Entering scan from manual always restarts the round-robin at channel 0.
  assign scan_start = (state == ST_SCAN) ? ptr : '0;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upper_mask[i] = ch_mask[i] && (SEL_W'(i) >= scan_start);
    end
  end

  // Wrap-around search: prefer channels at or above the pointer, otherwise the lowest enabled one.
  assign scan_hit  = |ch_mask;
  assign scan_ch   = (|upper_mask) ? lowest_set(upper_mask) : lowest_set(ch_mask);
  assign scan_next = (scan_ch == SEL_W'(NUM_CH - 1)) ? '0 : scan_ch + 1'b1;
  assign man_hit   = ({1'b0, sel} < (SEL_W + 1)'(NUM_CH));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cap_valid = 1'b0;
    cap_ch    = sel;
    ptr_next  = ptr;
    if (mode) begin
      ptr_next = scan_start;
      if (scan_hit) begin
        cap_valid = 1'b1;
        cap_ch    = scan_ch;
        ptr_next  = scan_next;
      end
    end else begin
      cap_valid = man_hit;
    end
    cap_data = cap_valid ? chan_data(in_data, cap_ch) : '0;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_MAN;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      state     <= mode ? ST_SCAN : ST_MAN;
      ptr       <= ptr_next;
      out_valid <= cap_valid;
      out_data  <= cap_data;
    end
  end

`ifdef MUX_CH_TAG_EN
  // Tag only moves with a real capture, so it always names the channel behind out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel <= '0;
    end else if (load && cap_valid) begin
      out_sel <= cap_ch;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1: directed steps plus random traffic against a behavioural model.
// A second instance with NUM_CH=24 covers the out-of-range manual select.
module tb_mux_scan_nto1;

  localparam int N   = 32;
  localparam int SW  = 5;
  localparam int N24 = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  ch_mask;
  logic [N-1:0]  in_data;
  logic          out_ready;
  logic          out_valid;
  logic [0:0]    out_data;
  logic [SW-1:0] out_sel;

  logic [SW-1:0]  sel24;
  logic [N24-1:0] mask24;
  logic [N24-1:0] in24;
  logic           valid24;
  logic [0:0]     data24;
  logic [SW-1:0]  osel24;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit     m_scan;
  int     m_ptr;
  bit     m_valid;
  bit     m_data;
  int     m_sel;
  bit     m24_valid;
  bit     m24_data;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.NUM_CH(N), .WIDTH(1), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .ch_mask   (ch_mask),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef MUX_CH_TAG_EN
    ,
    .out_sel   (out_sel)
`endif
  );

  mux_scan_nto1 #(.NUM_CH(N24), .WIDTH(1), .SEL_W(SW)) dut24 (
    .clk       (clk),
    .rst       (rst),
    .mode      (1'b0),
    .sel       (sel24),
    .ch_mask   (mask24),
    .in_data   (in24),
    .out_ready (1'b1),
    .out_valid (valid24),
    .out_data  (data24)
`ifdef MUX_CH_TAG_EN
    ,
    .out_sel   (osel24)
`endif
  );

`ifndef MUX_CH_TAG_EN
  assign out_sel = '0;
  assign osel24  = '0;
`endif

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_clock();
    int start;
    int c;
    bit found;
    if (rst) begin
      m_scan = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
      m24_valid = 0; m24_data = 0;
      return;
    end
    if (!m_valid || out_ready) begin
      if (mode) begin
        start = m_scan ? m_ptr : 0;
        found = 0;
        c = 0;
        for (int k = 0; k < N; k++) begin
          c = (start + k) % N;
          if (ch_mask[c]) begin
            found = 1;
            break;
          end
        end
        if (found) begin
          m_valid = 1; m_data = in_data[c]; m_sel = c; m_ptr = (c + 1) % N;
        end else begin
          m_valid = 0; m_data = 0; m_ptr = start;
        end
        m_scan = 1;
      end else begin
        m_scan = 0;
        m_valid = 1;
        m_data = in_data[sel];
        m_sel = int'(sel);
      end
    end
    m24_valid = (int'(sel24) < N24);
    m24_data  = m24_valid ? in24[sel24] : 1'b0;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (out_valid === m_valid) else begin
      n_errors++;
      $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, m_valid);
    end
    n_checks++;
    assert (out_data === m_data) else begin
      n_errors++;
      $error("FAIL %s out_data got %0b exp %0b", tag, out_data, m_data);
    end
`ifdef MUX_CH_TAG_EN
    if (m_valid) begin
      n_checks++;
      assert (int'(out_sel) === m_sel) else begin
        n_errors++;
        $error("FAIL %s out_sel got %0d exp %0d", tag, out_sel, m_sel);
      end
    end
`endif
  endtask

  task automatic check24(input string tag);
    n_checks++;
    assert (valid24 === m24_valid) else begin
      n_errors++;
      $error("FAIL %s valid24 got %0b exp %0b", tag, valid24, m24_valid);
    end
    n_checks++;
    assert (data24 === m24_data) else begin
      n_errors++;
      $error("FAIL %s data24 got %0b exp %0b", tag, data24, m24_data);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int exp_seq [5];
    exp_seq = '{0, 2, 8, 0, 2};

    rst = 1; mode = 0; sel = '0; ch_mask = '0; in_data = '0; out_ready = 1;
    sel24 = '0; mask24 = '0; in24 = '0;
    #1;

    // Reset for two cycles
    step();
    step();
    check("reset");
    check_val("reset_valid", int'(out_valid), 0);

    // Manual select
    rst = 0; in_data = 32'h0000_0002; sel = 5'd1;
    step();
    check("man_sel1");
    check_val("man_sel1_data", int'(out_data), 1);
    sel = 5'd0;
    step();
    check("man_sel0");
    check_val("man_sel0_data", int'(out_data), 0);

    // Backpressure holds the captured sample
    sel = 5'd1; in_data = 32'h0000_0002;
    step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = ~in_data;
      sel = SW'($urandom_range(0, N - 1));
      step();
      check("backpressure");
      check_val("bp_hold_data", int'(out_data), 1);
    end
    out_ready = 1; sel = 5'd3; in_data = 32'h0000_0008;
    step();
    check("bp_release");
    check_val("bp_release_data", int'(out_data), 1);

    // Scan order over mask 0x105
    mode = 1; ch_mask = 32'h0000_0105;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom();
      step();
      check("scan_order");
`ifdef MUX_CH_TAG_EN
      check_val("scan_order_sel", int'(out_sel), exp_seq[i]);
`endif
    end

    // Empty mask, then a single enabled channel
    ch_mask = '0;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom();
      step();
      check("empty_mask");
      check_val("empty_mask_valid", int'(out_valid), 0);
    end
    ch_mask = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom();
      step();
      check("single_ch");
    end

    // Reset in the middle of a scan
    ch_mask = 32'h0000_0105;
    for (int i = 0; i < 4 && !(m_valid && m_sel == 8); i++) begin
      in_data = $urandom();
      step();
      check("pre_reset_scan");
    end
    rst = 1;
    step();
    check("mid_scan_reset");
    check_val("mid_scan_reset_valid", int'(out_valid), 0);
    rst = 0; in_data = $urandom();
    step();
    check("post_reset_scan");
`ifdef MUX_CH_TAG_EN
    check_val("post_reset_sel", int'(out_sel), 0);
`endif

    // 24-channel instance: out-of-range selects are silently dropped
    sel24 = 5'd30; in24 = 24'hFF_FFFF;
    step();
    check24("n24_sel30");
    check_val("n24_sel30_valid", int'(valid24), 0);
    sel24 = 5'd23; in24 = 24'h80_0000;
    step();
    check24("n24_sel23");
    check_val("n24_sel23_data", int'(data24), 1);
    sel24 = 5'd24;
    step();
    check24("n24_sel24");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel       = SW'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      case ($urandom_range(0, 5))
        0:       ch_mask = '0;
        1:       ch_mask = 32'h1 << $urandom_range(0, N - 1);
        2, 3:    ch_mask = $urandom() & $urandom() & $urandom();
        default: ch_mask = $urandom();
      endcase
      sel24  = SW'($urandom_range(0, 31));
      in24   = N24'($urandom());
      mask24 = N24'($urandom());
      step();
      check("random");
      check24("random24");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
